// File: rtl/audio_pdm_out.sv
// Multi-channel PCM-to-PDM speaker output: one-frame holding register, per-period sample update,
// volume shift, per-channel mute and first-order sigma-delta. Define SOFT_MUTE_EN for ramped mute.
module audio_pdm_out #(
  parameter int NUM_CH        = 2,
  parameter int SAMPLE_W      = 16,
  parameter int SAMPLE_PERIOD = 2083,
  parameter int PDM_DIV       = 4
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic [NUM_CH*SAMPLE_W-1:0] sample_in,
  input  logic                       sample_valid_in,
  output logic                       sample_ready_out,
  input  logic [3:0]                 volume_in,
  input  logic [NUM_CH-1:0]          mute_in,
  input  logic                       clear_underrun_in,
  output logic [NUM_CH-1:0]          pdm_out,
  output logic                       sample_tick_out,
  output logic                       underrun_out
);

  localparam int CNT_W = $clog2(SAMPLE_PERIOD);
  localparam int DIV_W = (PDM_DIV > 1) ? $clog2(PDM_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_PERIOD - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PDM_DIV - 1);

  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic [DIV_W-1:0]                 div_q, div_d;
  logic                             tick_q, tick_d;
  logic                             hold_full_q, hold_full_d;
  logic [NUM_CH-1:0][SAMPLE_W-1:0]  hold_q, hold_d;
  logic [NUM_CH-1:0][SAMPLE_W-1:0]  active_q, active_d;
  logic [NUM_CH-1:0][SAMPLE_W-1:0]  acc_q, acc_d;
  logic [NUM_CH-1:0]                pdm_q, pdm_d;
  logic                             underrun_q, underrun_d;
  logic                             accept_s;
  logic                             strobe_s;

  logic signed [SAMPLE_W-1:0]       shifted_s [NUM_CH];
  logic signed [SAMPLE_W-1:0]       scaled_s  [NUM_CH];
  logic [NUM_CH-1:0][SAMPLE_W-1:0]  u_s;
  logic [NUM_CH-1:0][SAMPLE_W:0]    sum_s;

`ifdef SOFT_MUTE_EN
  logic [NUM_CH-1:0][4:0]           gain_q, gain_d;
  logic signed [SAMPLE_W+4:0]       prod_s [NUM_CH];
`endif

  assign sample_ready_out = !hold_full_q && !rst_in;
  assign accept_s         = sample_valid_in && sample_ready_out;
  assign pdm_out          = pdm_q;
  assign sample_tick_out  = tick_q;
  assign underrun_out     = underrun_q;

  // Period/PDM timing, frame hand-off from holding to active registers, underrun flag
  always_comb begin
    cnt_d       = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    tick_d      = (cnt_q == CNT_LAST);
    strobe_s    = (div_q == DIV_LAST);
    div_d       = strobe_s ? '0 : div_q + DIV_W'(1);
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    active_d    = active_q;
    underrun_d  = underrun_q;
    if (tick_q && hold_full_q) begin
      active_d    = hold_q;
      hold_full_d = 1'b0;
    end else begin
      active_d    = active_q;
    end
    // Ready is low at a tick with a full holding register, so accept never collides with the move.
    if (accept_s) begin
      hold_d      = sample_in;
      hold_full_d = 1'b1;
    end else begin
      hold_d      = hold_q;
    end
    if (tick_q && !hold_full_q) begin
      underrun_d = 1'b1;
    end else if (clear_underrun_in) begin
      underrun_d = 1'b0;
    end else begin
      underrun_d = underrun_q;
    end
  end

`ifdef SOFT_MUTE_EN
  // Per-channel gain ramps one step per sample tick toward 0 (muted) or 16 (unmuted)
  always_comb begin
    gain_d = gain_q;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (!tick_q) begin
        gain_d[ch] = gain_q[ch];
      end else if (mute_in[ch]) begin
        gain_d[ch] = (gain_q[ch] != 5'd0) ? gain_q[ch] - 5'd1 : gain_q[ch];
      end else begin
        gain_d[ch] = (gain_q[ch] != 5'd16) ? gain_q[ch] + 5'd1 : gain_q[ch];
      end
    end
  end
`endif

  // Per-channel attenuation, mute, offset-binary conversion and sigma-delta step
  always_comb begin
    acc_d = acc_q;
    pdm_d = pdm_q;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      shifted_s[ch] = $signed(active_q[ch]) >>> volume_in;
`ifdef SOFT_MUTE_EN
      prod_s[ch]    = {{5{shifted_s[ch][SAMPLE_W-1]}}, shifted_s[ch]}
                    * {{SAMPLE_W{1'b0}}, gain_q[ch]};
      scaled_s[ch]  = SAMPLE_W'(prod_s[ch] >>> 4);
`else
      scaled_s[ch]  = mute_in[ch] ? '0 : shifted_s[ch];
`endif
      u_s[ch]   = {~scaled_s[ch][SAMPLE_W-1], scaled_s[ch][SAMPLE_W-2:0]};
      sum_s[ch] = {1'b0, acc_q[ch]} + {1'b0, u_s[ch]};
      if (strobe_s) begin
        acc_d[ch] = sum_s[ch][SAMPLE_W-1:0];
        pdm_d[ch] = sum_s[ch][SAMPLE_W];
      end else begin
        acc_d[ch] = acc_q[ch];
        pdm_d[ch] = pdm_q[ch];
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q       <= '0;
      div_q       <= '0;
      tick_q      <= 1'b0;
      hold_full_q <= 1'b0;
      hold_q      <= '0;
      active_q    <= '0;
      acc_q       <= '0;
      pdm_q       <= '0;
      underrun_q  <= 1'b0;
`ifdef SOFT_MUTE_EN
      gain_q      <= {NUM_CH{5'd16}};
`endif
    end else begin
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      tick_q      <= tick_d;
      hold_full_q <= hold_full_d;
      hold_q      <= hold_d;
      active_q    <= active_d;
      acc_q       <= acc_d;
      pdm_q       <= pdm_d;
      underrun_q  <= underrun_d;
`ifdef SOFT_MUTE_EN
      gain_q      <= gain_d;
`endif
    end
  end

endmodule

// File: tb/tb_audio_pdm_out.sv
// Directed + randomized bench for audio_pdm_out; PDM densities are compared against a
// floor/ceil bound derived from an integer model of attenuation and offset-binary conversion.
module tb_audio_pdm_out;

  localparam int NUM_CH = 2;
  localparam int SW     = 16;
  localparam int SP     = 2083;
  localparam int PD     = 4;

  logic                   clk_in = 1'b0;
  logic                   rst_in;
  logic [NUM_CH*SW-1:0]   sample_in;
  logic                   sample_valid_in;
  logic                   sample_ready_out;
  logic [3:0]             volume_in;
  logic [NUM_CH-1:0]      mute_in;
  logic                   clear_underrun_in;
  logic [NUM_CH-1:0]      pdm_out;
  logic                   sample_tick_out;
  logic                   underrun_out;

  int checks = 0;
  int errors = 0;

  audio_pdm_out #(.NUM_CH(NUM_CH), .SAMPLE_W(SW), .SAMPLE_PERIOD(SP), .PDM_DIV(PD)) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .sample_in         (sample_in),
    .sample_valid_in   (sample_valid_in),
    .sample_ready_out  (sample_ready_out),
    .volume_in         (volume_in),
    .mute_in           (mute_in),
    .clear_underrun_in (clear_underrun_in),
    .pdm_out           (pdm_out),
    .sample_tick_out   (sample_tick_out),
    .underrun_out      (underrun_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_range(input string tag, input longint obs, input longint lo, input longint hi);
    logic in_rng;
    in_rng = (obs >= lo) && (obs <= hi);
    checks++;
    assert (in_rng === 1'b1) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Offset-binary level the modulator should average to, from plain integer arithmetic.
  function automatic longint model_u(input logic [15:0] raw, input int vol, input bit mute);
    longint v, d, s;
    v = raw[15] ? longint'(raw) - 65536 : longint'(raw);
    d = 1;
    for (int i = 0; i < vol; i++) d = d * 2;
    if (mute)        s = 0;
    else if (v >= 0) s = v / d;
    else             s = -((-v + d - 1) / d);
    return s + 32768;
  endfunction

  task automatic measure(input int n, input longint u0, input longint u1, input string tag);
    longint o0, o1;
    o0 = 0;
    o1 = 0;
    for (int i = 0; i < n; i++) begin
      repeat (PD) step();
      o0 += longint'(pdm_out[0]);
      o1 += longint'(pdm_out[1]);
    end
    chk_range({tag, "_ch0"}, o0, (n * u0) / 65536, (n * u0 + 65535) / 65536);
    chk_range({tag, "_ch1"}, o1, (n * u1) / 65536, (n * u1 + 65535) / 65536);
  endtask

  task automatic send_frame(input logic [31:0] f);
    int t;
    sample_in       = f;
    sample_valid_in = 1'b1;
    t = 0;
    while (!sample_ready_out && t < 3 * SP) begin step(); t++; end
    chk("send_ready", sample_ready_out, 1);
    step();
    sample_valid_in = 1'b0;
  endtask

  task automatic wait_tick();
    int t;
    t = 0;
    while (sample_tick_out !== 1'b1 && t < 3 * SP) begin step(); t++; end
    chk("tick_seen", sample_tick_out, 1);
  endtask

  task automatic apply(input logic [31:0] f, input int vol, input logic [1:0] m, input int n,
                       input string tag);
    send_frame(f);
    wait_tick();
    volume_in = 4'(vol);
    mute_in   = m;
    repeat (8) step();
    measure(n, model_u(f[15:0], vol, m[0]), model_u(f[31:16], vol, m[1]), tag);
  endtask

  // Release reset and check ready, first PDM strobes (zero sample), first tick and first underrun.
  task automatic release_check(input string tag);
    int first;
    rst_in = 1'b0;
    #1;
    chk({tag, "_ready"}, sample_ready_out, 1);
    first = 0;
    for (int k = 1; k <= SP + 7; k++) begin
      step();
      if (sample_tick_out && first == 0) first = k;
      if (k % 4 == 0 && k <= 16) chk({tag, "_pdm_pattern"}, pdm_out, (((k / 4) - 1) % 2 == 1) ? 3 : 0);
      if (k == SP)     chk({tag, "_underrun_pre"}, underrun_out, 0);
      if (k == SP + 1) chk({tag, "_underrun_post"}, underrun_out, 1);
    end
    chk({tag, "_first_tick"}, first, SP);
  endtask

  initial begin
    logic [31:0] f;
    int t, periods, acc, und_bad, vol;
    bit started;

    rst_in            = 1'b1;
    sample_in         = '0;
    sample_valid_in   = 1'b0;
    volume_in         = 4'd0;
    mute_in           = 2'b00;
    clear_underrun_in = 1'b0;
    repeat (3) step();
    chk("rst_ready", sample_ready_out, 0);
    chk("rst_pdm", pdm_out, 0);
    chk("rst_tick", sample_tick_out, 0);
    chk("rst_underrun", underrun_out, 0);
    release_check("rel1");

    apply(32'h8000_7FFF, 0, 2'b00, 4096, "full_scale");

    f = {16'($urandom), 16'h4000};
    apply(f, 1, 2'b00, 4096, "vol1");
    mute_in = 2'b01;
    repeat (8) step();
    measure(512, model_u(f[15:0], 1, 1'b1), model_u(f[31:16], 1, 1'b0), "mute0");

    for (int r = 0; r < 3; r++) begin
      f   = $urandom;
      vol = $urandom_range(0, 15);
      apply(f, vol, 2'($urandom_range(0, 3)), 512, "random");
    end
    volume_in = 4'd0;
    mute_in   = 2'b00;

    // Continuous valid: one accept per period, underrun stays clear.
    sample_in       = $urandom;
    sample_valid_in = 1'b1;
    t = 0;
    while (!sample_ready_out && t < 3 * SP) begin step(); t++; end
    step();
    clear_underrun_in = 1'b1;
    step();
    clear_underrun_in = 1'b0;
    periods = 0; acc = 0; und_bad = 0; started = 1'b0;
    for (int c = 0; c < 5 * SP && periods < 3; c++) begin
      if (sample_tick_out) begin
        if (started) begin chk("one_accept_per_period", acc, 1); periods++; end
        started = 1'b1;
        acc = 0;
      end
      if (sample_ready_out && sample_valid_in) acc++;
      if (underrun_out) und_bad++;
      step();
    end
    chk("stream_periods", periods, 3);
    chk("stream_no_underrun", und_bad, 0);
    sample_valid_in = 1'b0;

    // Clear in the same cycle as an underrunning tick: set wins.
    t = 0;
    while (!(sample_tick_out && sample_ready_out) && t < 4 * SP) begin step(); t++; end
    chk("empty_tick_found", sample_tick_out && sample_ready_out, 1);
    chk("underrun_before", underrun_out, 0);
    clear_underrun_in = 1'b1;
    step();
    clear_underrun_in = 1'b0;
    chk("set_wins", underrun_out, 1);
    repeat (3) step();
    chk("underrun_sticky", underrun_out, 1);
    clear_underrun_in = 1'b1;
    step();
    clear_underrun_in = 1'b0;
    chk("underrun_cleared", underrun_out, 0);

    // Reset mid-period with a full holding register.
    wait_tick();
    step();
    send_frame($urandom);
    repeat (5) step();
    chk("hold_full_pre_rst", sample_ready_out, 0);
    rst_in = 1'b1;
    step();
    chk("midrst_ready", sample_ready_out, 0);
    chk("midrst_pdm", pdm_out, 0);
    chk("midrst_tick", sample_tick_out, 0);
    chk("midrst_underrun", underrun_out, 0);
    release_check("rel2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_pdm_out.md
Name: audio_pdm_out

Overview:
Parametrised multi-channel speaker output stage that generalises the fixed stereo spkl/spkr drive to NUM_CH PDM channels.
- Accepts frames of signed PCM samples over a valid/ready handshake into a one-frame holding register.
- Consumes one frame per sample period, applies volume attenuation and per-channel mute, then drives each channel through a first-order sigma-delta modulator.
- Sits between the audio processing pipeline and the speaker pins on the 100 MHz domain.

Parameters:
- NUM_CH, 2, number of output channels.
- SAMPLE_W, 16, signed PCM sample width in bits.
- SAMPLE_PERIOD, 2083, clk_in cycles per sample (~48 kHz at 100 MHz); must be ≥ 4.
- PDM_DIV, 4, clk_in cycles per PDM bit update; must be ≥ 1.

Ports:
- clk_in  input  1  system clock (100 MHz).
- rst_in  input  1  synchronous active-high reset.
- sample_in  input  NUM_CH*SAMPLE_W  frame, channel 0 in LSBs, two's complement.
- sample_valid_in  input  1  frame valid.
- sample_ready_out  output  1  holding register empty.
- volume_in  input  4  attenuation as an arithmetic right shift, 0..15.
- mute_in  input  NUM_CH  per-channel mute.
- clear_underrun_in  input  1  clears the sticky underrun flag.
- pdm_out  output  NUM_CH  PDM bitstream per channel.
- sample_tick_out  output  1  one-cycle pulse at each sample boundary.
- underrun_out  output  1  sticky flag: a tick found the holding register empty.

Behaviour:
- Reset (synchronous, active-high): all state clears.
  - Period counter = 0, PDM divider = 0, holding register empty.
  - Active samples = 0, accumulators = 0.
  - pdm_out = 0, sample_tick_out = 0, underrun_out = 0.
  - sample_ready_out is 0 while rst_in is high.
  - Reset mid-frame discards held and active data; no partial output survives.
- sample_ready_out = !hold_full && !rst_in. It is combinational and does not depend on sample_valid_in.
- Accept: sample_valid_in && sample_ready_out at a rising edge latches the frame and sets hold_full.
- Period counter: counts 0..SAMPLE_PERIOD-1 and wraps. sample_tick_out is registered high for exactly the cycle after the counter reaches SAMPLE_PERIOD-1.
  - The first tick is cycle SAMPLE_PERIOD after reset release.
- At tick, with hold_full = 1:
  - Holding contents move to the active registers and hold_full clears.
  - sample_ready_out is 0 that cycle, so no simultaneous accept can occur.
- At tick, with hold_full = 0 (underrun):
  - Active samples repeat their previous values and underrun_out sets.
  - A frame accepted in that same cycle goes to the holding register and is not used for this period.
- underrun_out clears on clear_underrun_in. If clear and a new underrun land in the same cycle, set wins.
- Per-channel data path, recomputed combinationally from the active samples:
  - s = mute_in[ch] ? 0 : (active >>> volume_in).
  - The shift is arithmetic; volume 15 leaves only sign-extension.
  - u = s with MSB inverted (offset binary, 0..2^SAMPLE_W-1).
- Sigma-delta, one step per PDM strobe (every PDM_DIV cycles, divider wraps):
  - acc_next = {1'b0, acc[SAMPLE_W-1:0]} + u, held at SAMPLE_W+1 bits.
  - pdm_out[ch] = acc_next[SAMPLE_W], registered.
  - Average density = u / 2^SAMPLE_W.
- Mute, volume and active-sample changes take effect at the next PDM strobe. The accumulator is never cleared except by reset.

Optional Feature:
SOFT_MUTE_EN
- Defined:
  - Each channel has a gain register 0..16, reset value 16.
  - At each sample tick, gain steps −1 toward 0 while mute_in[ch] = 1 and +1 toward 16 while mute_in[ch] = 0.
  - s = ((active >>> volume_in) * gain) >>> 4, with a signed multiply of width SAMPLE_W+5 truncated back to SAMPLE_W.
  - A full mute or unmute therefore ramps over 16 sample periods.
- Undefined: mute is instantaneous as described above; no gain registers are built.

Test Plan:
- Reset release, NUM_CH=2, no frames → sample_ready_out=1 from cycle 1; first sample_tick_out at cycle 2083; underrun_out=1 the cycle after; pdm_out pattern 0,1,0,1 per PDM strobe (u=0x8000, zero sample).
- Send frame ch0=0x7FFF, ch1=0x8000, volume 0 → over 4096 PDM strobes after the next tick, ch0 ones-count = 4095 ±1, ch1 ones-count = 0.
- Hold valid high continuously → exactly one accept per sample period; ready low from accept until the following tick; no underrun after the first frame.
- ch0=0x4000, volume_in=1 → ch0 density 0.625 (u=0xA000), i.e. 2560 ±1 ones per 4096 strobes; mute_in[0]=1 → density 0.5 alternating.
- Underrun with clear_underrun_in asserted in the same cycle as the tick → underrun_out=1; clear pulse in a later cycle → 0.
- Assert rst_in mid-period with hold_full=1 → next cycle ready=0, all pdm_out=0; after release the counter restarts and the first tick lands at SAMPLE_PERIOD again.
